// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e : hazard FSM state encoding (RUN=0, WAIT=1, ERR=2)
//   REG_ADDR_W   : register-address width used by the ID/EX comparators
//   TIMEOUT_DEF  : default maximum consecutive memory-wait cycles
//   CNT_W_DEF    : default width of the stall/flush statistics counters
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W  = 3;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hazard statistics.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset, clears the count
//   inc   : advance the count by one (ignored once all-ones)
//   clear : synchronous clear, takes priority over inc
//   value : current count
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clear) begin
            value_d = '0;
        end else if (inc && (value_q != '1)) begin
            value_d = value_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves memory freeze, taken branches and
// load-use hazards into pipeline-register write enables and bubble flushes,
// with a memory-wait watchdog that latches into a sticky error state.
//   clk, rst                     : clock, asynchronous active-high reset
//   id_rs1/id_rs2, id_useRs1/2   : ID-stage source registers and their use
//   ex_memRd, ex_rd              : EX-stage load flag and destination
//   branchTaken                  : EX-stage branch resolved taken
//   memReq, memReady             : MEM-stage request / data-memory ready
//   pcWr..memwbWr                : pipeline-register write enables
//   ifidFlush, idexFlush         : bubble insertion
//   memTimeout                   : sticky watchdog error flag
//   stallCnt, flushCnt           : saturating event counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_useRs1,
    input  logic                  id_useRs2,
    input  logic                  ex_memRd,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  branchTaken,
    input  logic                  memReq,
    input  logic                  memReady,
    output logic                  pcWr,
    output logic                  ifidWr,
    output logic                  idexWr,
    output logic                  exmemWr,
    output logic                  memwbWr,
    output logic                  ifidFlush,
    output logic                  idexFlush,
    output logic                  memTimeout,
    output logic [CNT_W-1:0]      stallCnt,
    output logic [CNT_W-1:0]      flushCnt
);

    localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    ctrl_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q, wcnt_d;

    logic freeze;
    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign freeze   = memReq && !memReady;
    // R0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use = ex_memRd && (ex_rd != '0) &&
                      ((id_useRs1 && (id_rs1 == ex_rd)) ||
                       (id_useRs2 && (id_rs2 == ex_rd)));

    always_comb begin
        pcWr      = 1'b0;
        ifidWr    = 1'b0;
        idexWr    = 1'b0;
        exmemWr   = 1'b0;
        memwbWr   = 1'b0;
        ifidFlush = 1'b0;
        idexFlush = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        state_d   = state_q;
        wcnt_d    = wcnt_q;

        // Outputs are forced idle for as long as reset is held.
        if (!rst) begin
            case (state_q)
                RUN, WAIT: begin
                    if (freeze) begin
                        stall_inc = 1'b1;
                    end else if (branchTaken) begin
                        {pcWr, ifidWr, idexWr, exmemWr, memwbWr} = '1;
                        ifidFlush = 1'b1;
                        idexFlush = 1'b1;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        {idexWr, exmemWr, memwbWr} = '1;
                        idexFlush = 1'b1;
                        stall_inc = 1'b1;
                    end else begin
                        {pcWr, ifidWr, idexWr, exmemWr, memwbWr} = '1;
                    end

                    if (state_q == RUN) begin
                        if (freeze) begin
                            state_d = WAIT;
                            wcnt_d  = WAIT_W'(1);
                        end
                    end else begin
                        if (!freeze) begin
                            state_d = RUN;
                            wcnt_d  = '0;
                        end else if (wcnt_q == WAIT_W'(TIMEOUT)) begin
                            state_d = ERR;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign memTimeout = (state_q == ERR);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clear (1'b0),
        .value (stallCnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clear (1'b0),
        .value (flushCnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_useRs1, id_useRs2, ex_memRd, branchTaken, memReq, memReady;
    logic       pcWr, ifidWr, idexWr, exmemWr, memwbWr, ifidFlush, idexFlush;
    logic       memTimeout;
    logic [7:0] stallCnt, flushCnt;

    int checks = 0;
    int errors = 0;

    // Enable/flush pattern order: pcWr ifidWr idexWr exmemWr memwbWr ifidFlush idexFlush
    localparam logic [6:0] P_IDLE   = 7'b0000000;
    localparam logic [6:0] P_NORMAL = 7'b1111100;
    localparam logic [6:0] P_LDUSE  = 7'b0011101;
    localparam logic [6:0] P_BRANCH = 7'b1111111;

    pipe_hazard_ctrl #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_useRs1   (id_useRs1),
        .id_useRs2   (id_useRs2),
        .ex_memRd    (ex_memRd),
        .ex_rd       (ex_rd),
        .branchTaken (branchTaken),
        .memReq      (memReq),
        .memReady    (memReady),
        .pcWr        (pcWr),
        .ifidWr      (ifidWr),
        .idexWr      (idexWr),
        .exmemWr     (exmemWr),
        .memwbWr     (memwbWr),
        .ifidFlush   (ifidFlush),
        .idexFlush   (idexFlush),
        .memTimeout  (memTimeout),
        .stallCnt    (stallCnt),
        .flushCnt    (flushCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pat(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, pcWr, ifidWr, idexWr, exmemWr, memwbWr, ifidFlush, idexFlush},
            {25'd0, exp});
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_useRs1 = 1'b0; id_useRs2 = 1'b0; ex_memRd = 1'b0;
        branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
    endtask

    // Advance through one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #12;
        chk_pat("reset_outs", P_IDLE);
        chk("reset_stall", {24'd0, stallCnt}, 32'd0);
        chk("reset_flush", {24'd0, flushCnt}, 32'd0);
        chk("reset_timeout", {31'd0, memTimeout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_pat("normal", P_NORMAL);

        // Load targeting R0 never stalls.
        ex_memRd = 1'b1; ex_rd = 3'd0; id_rs1 = 3'd0; id_useRs1 = 1'b1;
        #1 chk_pat("r0_no_stall", P_NORMAL);
        tick();
        chk("r0_stall_cnt", {24'd0, stallCnt}, 32'd0);

        // Matching rs2 but unused: no hazard.
        @(negedge clk);
        clear_inputs();
        ex_memRd = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_useRs2 = 1'b0;
        #1 chk_pat("unused_rs2", P_NORMAL);

        // Load-use via rs2: one bubble.
        id_useRs2 = 1'b1;
        #1 chk_pat("lduse", P_LDUSE);
        tick();
        chk("lduse_stall_cnt", {24'd0, stallCnt}, 32'd1);
        @(negedge clk);
        ex_memRd = 1'b0;
        #1 chk_pat("lduse_resolved", P_NORMAL);
        tick();
        chk("lduse_once", {24'd0, stallCnt}, 32'd1);

        // Branch together with load-use: branch wins.
        @(negedge clk);
        ex_memRd = 1'b1; branchTaken = 1'b1;
        #1 chk_pat("branch_over_lduse", P_BRANCH);
        tick();
        chk("branch_flush_cnt", {24'd0, flushCnt}, 32'd1);
        chk("branch_stall_cnt", {24'd0, stallCnt}, 32'd1);

        // Memory wait: four frozen cycles, then ready.
        @(negedge clk);
        clear_inputs();
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk_pat("freeze", P_IDLE);
            @(negedge clk);
        end
        chk("wait_stall_cnt", {24'd0, stallCnt}, 32'd5);
        memReady = 1'b1;
        #1 chk_pat("wait_release", P_NORMAL);
        tick();
        chk("wait_no_timeout", {31'd0, memTimeout}, 32'd0);

        // Freeze beats branch and load-use; then leave WAIT by dropping memReq.
        @(negedge clk);
        memReady = 1'b0; branchTaken = 1'b1;
        ex_memRd = 1'b1; ex_rd = 3'd5; id_rs1 = 3'd5; id_useRs1 = 1'b1;
        #1 chk_pat("freeze_over_branch", P_IDLE);
        tick();
        chk("freeze_no_flush_cnt", {24'd0, flushCnt}, 32'd1);
        chk("freeze_stall_once", {24'd0, stallCnt}, 32'd6);
        @(negedge clk);
        clear_inputs();
        #1 chk_pat("wait_exit_noreq", P_NORMAL);
        tick();

        // Timeout: RUN entry cycle plus 15 WAIT cycles, then ERR.
        @(negedge clk);
        memReq = 1'b1; memReady = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("pre_timeout", {31'd0, memTimeout}, 32'd0);
        chk_pat("pre_timeout_outs", P_IDLE);
        tick();
        chk("timeout_hit", {31'd0, memTimeout}, 32'd1);
        for (int i = 0; i < 4; i++) tick();
        chk("timeout_sticky", {31'd0, memTimeout}, 32'd1);
        chk("timeout_stall_cnt", {24'd0, stallCnt}, 32'd22);
        @(negedge clk);
        memReady = 1'b1; branchTaken = 1'b1;
        #1 chk_pat("err_holds_idle", P_IDLE);
        tick();
        chk("err_sticky_ready", {31'd0, memTimeout}, 32'd1);
        chk("err_no_flush_cnt", {24'd0, flushCnt}, 32'd1);
        chk("err_no_stall_cnt", {24'd0, stallCnt}, 32'd22);

        // Asynchronous reset out of ERR.
        #2 rst = 1'b1;
        #1;
        chk("rst_timeout_clear", {31'd0, memTimeout}, 32'd0);
        chk("rst_stall_clear", {24'd0, stallCnt}, 32'd0);
        chk("rst_flush_clear", {24'd0, flushCnt}, 32'd0);
        chk_pat("rst_outs_idle", P_IDLE);
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        #1 chk_pat("post_rst_normal", P_NORMAL);

        // Saturation under continuous load-use.
        ex_memRd = 1'b1; ex_rd = 3'd7; id_rs1 = 3'd7; id_useRs1 = 1'b1;
        #1 chk_pat("sat_lduse", P_LDUSE);
        for (int i = 0; i < 254; i++) tick();
        chk("sat_254", {24'd0, stallCnt}, 32'd254);
        tick();
        chk("sat_255", {24'd0, stallCnt}, 32'd255);
        for (int i = 0; i < 45; i++) tick();
        chk("sat_hold", {24'd0, stallCnt}, 32'd255);
        chk_pat("sat_still_lduse", P_LDUSE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of consecutive memory-wait cycles before the error state is entered.
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the stall and flush statistics counters.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 SHALL have rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have id_rs1, id_rs2  input  3 each  ID-stage source register addresses.
REQ-006 SHALL have id_useRs1, id_useRs2  input  1 each  ID instruction reads rs1 / rs2.
REQ-007 SHALL have ex_memRd  input  1  EX-stage instruction is a load.
REQ-008 SHALL have ex_rd  input  3  EX-stage destination register.
REQ-009 SHALL have branchTaken  input  1  EX-stage branch resolved as taken.
REQ-010 SHALL have memReq, memReady  input  1 each  MEM-stage access request and data-memory ready.
REQ-011 SHALL have pcWr, ifidWr, idexWr, exmemWr, memwbWr  output  1 each  pipeline-register write enables.
REQ-012 SHALL have ifidFlush, idexFlush  output  1 each  insert bubble into IF_ID / ID_EX.
REQ-013 SHALL have memTimeout  output  1  sticky error flag.
REQ-014 SHALL have stallCnt, flushCnt  output  CNT_W each  saturating event counters.

Function
REQ-015 SHALL compute all enables and flushes combinationally from the current state and inputs, with zero-cycle latency.
REQ-016 SHALL define a load-use hazard as ex_memRd=1, ex_rd!=0, and either (id_useRs1 and id_rs1==ex_rd) or (id_useRs2 and id_rs2==ex_rd); R0 never hazards.
REQ-017 SHALL define freeze as memReq=1 and memReady=0 in state RUN or WAIT.
REQ-018 SHALL apply priority freeze > branch > load-use > normal.
REQ-019 SHALL, on freeze, drive all five enables to 0 and both flushes to 0.
REQ-020 SHALL, on branch, drive all enables to 1, ifidFlush=1 and idexFlush=1, discarding any load-use hazard.
REQ-021 SHALL, on load-use, drive pcWr=0, ifidWr=0, idexFlush=1, and all other enables to 1, giving exactly one bubble per hazard.
REQ-022 SHALL, in the normal case, drive all enables to 1 and both flushes to 0.
REQ-023 SHALL implement FSM states RUN, WAIT and ERR.
REQ-024 SHALL transition RUN->WAIT on freeze, with the wait counter loaded to 1.
REQ-025 SHALL, in WAIT, return to RUN when memReady=1 or memReq=0, with the wait counter cleared; otherwise it SHALL increment the wait counter.
REQ-026 SHALL transition WAIT->ERR when the wait counter equals TIMEOUT and memReady is still 0.
REQ-027 SHALL, in ERR, hold all enables and flushes at 0 and memTimeout=1 until reset; ERR is left only by rst.
REQ-028 SHALL increment stallCnt once per cycle in which freeze or load-use is active, saturating at all-ones.
REQ-029 SHALL increment flushCnt once per branch cycle, saturating at all-ones.
REQ-030 SHALL not increment either counter in ERR.

Reset
REQ-031 SHALL, while rst=1, set state to RUN, clear the wait counter, stallCnt, flushCnt and memTimeout to 0, and hold all enables and flushes at 0.
REQ-032 SHALL, on assertion of rst mid-wait or in ERR, abort immediately with no pending stall carried over.
REQ-033 SHALL resume normal behaviour on the first rising clk edge after rst deasserts.

Structure
REQ-034 SHALL place the state encoding (RUN=0, WAIT=1, ERR=2), REG_ADDR_W=3 and the TIMEOUT and CNT_W defaults in the shared package pipe_ctrl_pkg.
REQ-035 SHALL instantiate the sub-module sat_counter (parameter width, inc, clear, value) for stallCnt and flushCnt.
REQ-036 SHALL keep the wait counter local to the block.

Verification
REQ-037 SHALL cover load-use: ex_memRd=1, ex_rd=3, id_rs2=3, id_useRs2=1 -> one cycle of pcWr=0, ifidWr=0, idexFlush=1, stallCnt 0->1.
REQ-038 SHALL cover R0: ex_memRd=1, ex_rd=0, id_rs1=0 -> no stall, all enables 1.
REQ-039 SHALL cover simultaneous events: branchTaken=1 together with a load-use hazard -> both flushes 1, pcWr=1, flushCnt+1, stallCnt unchanged.
REQ-040 SHALL cover memory wait: memReq=1, memReady=0 for 4 cycles, then 1 -> enables 0 for 4 cycles, stallCnt=4, back to RUN, memTimeout=0.
REQ-041 SHALL cover timeout: memReady held 0 for 20 cycles -> ERR reached after TIMEOUT cycles, memTimeout=1 sticky, all enables 0; pulsing rst -> RUN with counters at 0.
REQ-042 SHALL cover saturation: 300 load-use cycles with CNT_W=8 -> stallCnt=255 and held there.
